// File: rtl/flexbex_ibex_efpga_mch_pkg.sv
// flexbex_ibex_efpga_pkg: shared definitions for the multi-channel eFPGA
// custom-instruction controller.
//   efpga_state_e : controller FSM encoding (IDLE/WAIT_DLY/WAIT_DONE/RESP)
//   MODE_DELAY/MODE_DONE : values of mode_i
//   cnt_width()   : width of the shared delay/timeout counter
package flexbex_ibex_efpga_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DLY  = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } efpga_state_e;

  localparam logic MODE_DELAY = 1'b0;
  localparam logic MODE_DONE  = 1'b1;

  // One counter serves both modes: it must hold any delay_i value and count
  // up to TIMEOUT-1, so it never wraps.
  function automatic int cnt_width(input int delay_w, input int timeout);
    int tw;
    tw = $clog2(timeout + 1);
    return (delay_w > tw) ? delay_w : tw;
  endfunction

endpackage

// File: rtl/flexbex_ibex_efpga_mch_if.sv
// flexbex_ibex_efpga_mch_if: EX-stage <-> eFPGA controller signal bundle.
//   slave  : controller side (instruction/eFPGA inputs in, strobe/result out)
//   master : EX stage / testbench side
interface flexbex_ibex_efpga_mch_if #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 4,
  parameter int OP_W    = $clog2(N_CH)
);
  logic                     en_i;
  logic [OP_W-1:0]          operator_i;
  logic                     mode_i;
  logic [DELAY_W-1:0]       delay_i;
  logic [N_CH*DATA_W-1:0]   result_i;
  logic                     efpga_done_i;
  logic                     write_strobe_o;
  logic                     ready_o;
  logic [DATA_W-1:0]        endresult_o;
  logic                     timeout_o;
  logic                     busy_o;

  modport slave (
    input  en_i, operator_i, mode_i, delay_i, result_i, efpga_done_i,
    output write_strobe_o, ready_o, endresult_o, timeout_o, busy_o
  );

  modport master (
    output en_i, operator_i, mode_i, delay_i, result_i, efpga_done_i,
    input  write_strobe_o, ready_o, endresult_o, timeout_o, busy_o
  );
endinterface

// File: rtl/flexbex_ibex_efpga_mch.sv
// flexbex_ibex_efpga_mch: multi-channel eFPGA custom-instruction controller.
// Launches an eFPGA op with a one-cycle write strobe, then waits either a
// fixed delay (mode 0) or efpga_done_i (mode 1, with timeout), latches the
// selected result channel and pulses ready_o for one cycle.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of flexbex_ibex_efpga_mch_if (en/operator/mode/delay/
//          result/done in; write_strobe/ready/endresult/timeout/busy out)
module flexbex_ibex_efpga_mch
  import flexbex_ibex_efpga_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 4,
  parameter int TIMEOUT = 255,
  parameter int OP_W    = $clog2(N_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  flexbex_ibex_efpga_mch_if.slave   bus
);

  localparam int               CNT_W   = cnt_width(DELAY_W, TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  efpga_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              to_q, to_d;
  logic              strobe;
  logic [DATA_W-1:0] ch_sel;

  // Channel select uses the operator captured at launch, not the live input.
  assign ch_sel = bus.result_i[32'(sel_q)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    res_d   = res_q;
    to_d    = to_q;
    strobe  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en_i) begin
          strobe = 1'b1;
          sel_d  = bus.operator_i;
          if (bus.mode_i == MODE_DONE) begin
            cnt_d   = '0;
            state_d = WAIT_DONE;
          end else begin
            cnt_d   = CNT_W'(bus.delay_i);
            state_d = WAIT_DLY;
          end
        end
      end
      WAIT_DLY: begin
        // en_i dropping means EX flushed the instruction: abort silently.
        if (!bus.en_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          res_d   = ch_sel;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        // done is checked before the timeout so a late done still wins.
        if (!bus.en_i) begin
          state_d = IDLE;
        end else if (bus.efpga_done_i) begin
          res_d   = ch_sel;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          res_d   = '0;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        to_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.write_strobe_o = strobe;
  assign bus.ready_o        = (state_q == RESP);
  assign bus.timeout_o      = to_q;
  assign bus.busy_o         = (state_q == WAIT_DLY) || (state_q == WAIT_DONE);
  assign bus.endresult_o    = res_q;

endmodule

// File: tb/tb_flexbex_ibex_efpga_mch.sv
module tb_flexbex_ibex_efpga_mch;
  import flexbex_ibex_efpga_pkg::*;

  localparam int N_CH    = 4;
  localparam int DATA_W  = 32;
  localparam int DELAY_W = 4;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic [DATA_W-1:0] val;
    logic              to;
    int                lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flexbex_ibex_efpga_mch_if #(.N_CH(N_CH), .DATA_W(DATA_W), .DELAY_W(DELAY_W)) bus ();

  flexbex_ibex_efpga_mch #(
    .N_CH(N_CH), .DATA_W(DATA_W), .DELAY_W(DELAY_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   strobe_cyc = 0;
  int   nstrobe = 0;
  int   exp_strobes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: records strobes, pops the scoreboard on every ready pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.write_strobe_o) begin
        strobe_cyc = cyc;
        nstrobe++;
      end
      if (bus.timeout_o && !bus.ready_o) chk("timeout_without_ready", 64'(bus.timeout_o), 64'd0);
      if (bus.ready_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 64'(bus.ready_o), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("endresult", 64'(bus.endresult_o), 64'(e.val));
          chk("timeout",   64'(bus.timeout_o),   64'(e.to));
          chk("latency",   64'(cyc - strobe_cyc), 64'(e.lat));
        end
      end
    end
  end

  // Drive an op and wait for its ready pulse. lead=1 means the inputs are
  // being set during a RESP cycle so the strobe lands one cycle later.
  // done_at: cycle (relative to strobe) in which efpga_done_i is high; -1 never.
  task automatic run_op(input logic [1:0] op, input logic md, input logic [3:0] dly,
                        input int done_at, input logic [DATA_W-1:0] ev, input logic eto,
                        input int elat, input bit keep_en, input bit lead);
    exp_t e;
    int   k;
    bit   seen;
    e.val = ev; e.to = eto; e.lat = elat;
    exp_q.push_back(e);
    exp_strobes++;
    bus.en_i = 1'b1; bus.operator_i = op; bus.mode_i = md; bus.delay_i = dly;
    // A done in the strobe cycle must be ignored.
    bus.efpga_done_i = md;
    k = lead ? -1 : 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) bus.operator_i = ~op;
      bus.efpga_done_i = md && (k == done_at);
      if (k == 0) bus.efpga_done_i = md;
      if (bus.ready_o) seen = 1;
    end
    if (!seen) chk("ready_wait_expired", 64'd0, 64'd1);
    bus.efpga_done_i = 1'b0;
    if (!keep_en) bus.en_i = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] last;
    bus.en_i = 0; bus.operator_i = 0; bus.mode_i = 0; bus.delay_i = 0; bus.efpga_done_i = 0;
    for (int c = 0; c < N_CH; c++) bus.result_i[c*DATA_W +: DATA_W] = 32'hCAFE_0000 + c;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  64'(bus.ready_o), 64'd0);
    chk("rst_busy",   64'(bus.busy_o), 64'd0);
    chk("rst_strobe", 64'(bus.write_strobe_o), 64'd0);
    chk("rst_res",    64'(bus.endresult_o), 64'd0);
    chk("rst_to",     64'(bus.timeout_o), 64'd0);
    @(posedge clk); #1; rst = 0;

    // 1: fixed delay 3, ch2
    @(posedge clk); #1;
    run_op(2'd2, MODE_DELAY, 4'd3, -1, 32'hCAFE_0002, 1'b0, 5, 0, 0);
    // 2: delay 0 and 15
    @(posedge clk); #1;
    run_op(2'd0, MODE_DELAY, 4'd0, -1, 32'hCAFE_0000, 1'b0, 2, 0, 0);
    @(posedge clk); #1;
    run_op(2'd1, MODE_DELAY, 4'd15, -1, 32'hCAFE_0001, 1'b0, 17, 0, 0);
    // 3: done mode, done 6 cycles after strobe
    @(posedge clk); #1;
    run_op(2'd1, MODE_DONE, 4'd0, 6, 32'hCAFE_0001, 1'b0, 7, 0, 0);
    // 4: timeout, then done on last wait cycle
    @(posedge clk); #1;
    run_op(2'd2, MODE_DONE, 4'd0, -1, 32'h0, 1'b1, 9, 0, 0);
    @(posedge clk); #1;
    run_op(2'd3, MODE_DONE, 4'd0, 8, 32'hCAFE_0003, 1'b0, 9, 0, 0);
    // endresult held after the op; change inputs to show it is latched
    last = bus.endresult_o;
    bus.result_i[3*DATA_W +: DATA_W] = 32'h1234_5678;
    repeat (2) @(posedge clk); #1;
    chk("result_stable", 64'(bus.endresult_o), 64'hCAFE_0003);
    bus.result_i[3*DATA_W +: DATA_W] = 32'hCAFE_0003;

    // 5a: flush in WAIT_DLY
    @(posedge clk); #1;
    exp_strobes++;
    bus.en_i = 1; bus.operator_i = 2'd1; bus.mode_i = MODE_DELAY; bus.delay_i = 4'd5;
    repeat (2) @(posedge clk); #1;
    chk("abort_busy_before", 64'(bus.busy_o), 64'd1);
    bus.en_i = 0;
    @(posedge clk); #1;
    chk("abort_busy_after", 64'(bus.busy_o), 64'd0);
    repeat (8) @(posedge clk); #1;
    chk("abort_res_kept", 64'(bus.endresult_o), 64'(last));
    // 5b: reset in WAIT_DONE
    exp_strobes++;
    bus.en_i = 1; bus.operator_i = 2'd2; bus.mode_i = MODE_DONE;
    repeat (3) @(posedge clk); #1;
    rst = 1; bus.en_i = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_mid_busy",  64'(bus.busy_o), 64'd0);
    chk("rst_mid_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_mid_res",   64'(bus.endresult_o), 64'd0);
    repeat (12) @(posedge clk); #1;
    // fresh op after reset
    run_op(2'd2, MODE_DELAY, 4'd1, -1, 32'hCAFE_0002, 1'b0, 3, 0, 0);

    // 6: back-to-back, en held across RESP
    @(posedge clk); #1;
    run_op(2'd0, MODE_DELAY, 4'd1, -1, 32'hCAFE_0000, 1'b0, 3, 1, 0);
    run_op(2'd3, MODE_DELAY, 4'd2, -1, 32'hCAFE_0003, 1'b0, 4, 0, 1);

    repeat (4) @(posedge clk); #1;
    chk("strobe_count", 64'(nstrobe), 64'(exp_strobes));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1);
  end

endmodule
